cl_rx_deframer: RTL and testbench
=================================

Name: cl_rx_deframer

Overview:
- Receive-side Camera Link deframer for the 28-bit parallel bus from the LVDS deserializer.
- Recovers FVAL/LVAL/DVAL and the 16-bit pixel word from the fixed Base-config bit mapping.
- Counts pixels per line and lines per frame, checks them against the mode-selected geometry, and writes valid pixels into a downstream FIFO.
- Counterpart of our Camera Link frame transmitter, for loopback and board-to-board capture.

Parameters:
- H_FULL, 1024, pixels per line when mode=1
- V_FULL, 1024, lines per frame when mode=1
- H_HALF, 1032, pixels per line when mode=0
- V_HALF, 512, lines per frame when mode=0

Ports:
- rxClk  in  1  deserializer output clock; all logic on rising edge
- nrst  in  1  reset, synchronous, active-low
- rx  in  28  deserialized Camera Link bus
- mode  in  1  geometry select (1: FULL, 0: HALF); sampled at frame start
- enable  in  1  capture enable; sampled at frame start
- fifo_full  in  1  downstream FIFO full
- err_clr  in  1  one-cycle pulse clearing sticky error flags
- wr_en  out  1  FIFO write strobe
- pix_out  out  16  recovered pixel
- frame_start  out  1  one-cycle pulse on accepted frame start
- frame_done  out  1  one-cycle pulse on frame end
- frame_cnt  out  16  completed frames, wraps
- last_line_len  out  11  pixel count of most recently closed line
- line_len_err  out  1  sticky
- frame_len_err  out  1  sticky
- overflow  out  1  sticky; pixel dropped on fifo_full

Behaviour:
- Stage 1: rx_q <= rx every cycle, including reset.
- Decode from rx_q:
  - fval=rx_q[25], lval=rx_q[24], dval=rx_q[26]
  - pix[12:8]=rx_q[4:0], pix[15]=rx_q[5], pix[13]=rx_q[6], pix[14]=rx_q[27]
  - pix[2:0]=rx_q[9:7], pix[5:3]=rx_q[14:12], pix[7:6]=0
  - rx_q[11:10] and rx_q[23:15] ignored.
- Stage 2: wr_en/pix_out registered. A word on rx before edge k appears on wr_en/pix_out after edge k+1 (2-cycle latency).
- Reset (nrst=0 at edge):
  - state=SYNC; all outputs 0; counters 0; pix_out=0.
  - Applies mid-frame; the partial frame is discarded.
- States:
  - SYNC: wait for fval=0, then go to IDLE. Prevents capturing a partial frame.
  - IDLE, fval=1:
    - Latch mode into h_exp/v_exp, latch enable into cap_en.
    - Pulse frame_start; line_cnt=0, pix_cnt=0.
    - lval=0 -> go to BLANK.
    - lval=1 (FVAL and LVAL rising together) -> go directly to LINE and count this word as a pixel.
  - BLANK, fval=0 -> end-of-frame. BLANK, lval=1 -> go to LINE, counting the word if dval=1.
  - LINE:
    - lval=1 and dval=1: pixel. pix_cnt+1, saturating at 2047.
    - lval=0: line close:
      - last_line_len=pix_cnt
      - line_len_err set if pix_cnt != h_exp
      - line_cnt+1, saturating at 2047
      - pix_cnt=0
      - then go to BLANK, or do end-of-frame in the same cycle if fval=0
    - lval=1 with fval=0: treat as line close plus end-of-frame.
  - End-of-frame:
    - frame_len_err set if line_cnt (including a line closed this cycle) != v_exp
    - frame_done pulse; frame_cnt+1 (wraps at 65535 to 0)
    - go to IDLE
- Pixel write:
  - wr_en=1 when pixel && cap_en && !fifo_full.
  - pixel && cap_en && fifo_full -> word dropped, overflow set, pix_cnt still increments.
  - cap_en=0 -> counting and checks still run, no writes.
- Sticky flags: cleared only by err_clr or reset. A set and a clear in the same cycle -> set wins.
- mode/enable changes mid-frame have no effect until the next frame start.
- dval=1 with lval=0 is not counted and not written.

Test Plan:
- Geometry H_FULL=8, V_FULL=4. Drive mode=1, enable=1, fval and lval rising together, 4 lines of 8 pixels 0x0100..0x0107, 3 blank cycles between lines. Required: 32 wr_en pulses, each pix_out equal to the driven pixel with [7:6] zeroed, 2 cycles after rx; frame_start and frame_done one pulse each; frame_cnt=1; no error flags; last_line_len=8.
- Same stimulus, third line 7 pixels. Required: line_len_err=1 after that line, frame_len_err=0, last_line_len=7 until the next line closes. err_clr pulse -> 0.
- Frame of 3 lines with V_FULL=4. Required: frame_len_err=1 coincident with frame_done.
- Hold fifo_full=1 for pixels 2..4 of line 1. Required: 5 writes in that line, overflow=1, line_len_err=0.
- Assert nrst mid-line, release while fval still high. Required: no wr_en and no frame_start until fval has gone low and then high again; outputs 0 during reset.
- Toggle mode 1->0 mid-frame. Required: current frame still checked against FULL; next frame checked against HALF (H_HALF=6, V_HALF=2 override).

Source files
------------

// File: rtl/cl_rx_deframer.sv
// cl_rx_deframer
//   Receive-side Camera Link (Base config) deframer. It takes the 28-bit
//   parallel bus from the LVDS deserializer and recovers FVAL/LVAL/DVAL and
//   the 16-bit pixel word. It counts pixels per line and lines per frame,
//   checks both against the geometry selected by `mode`, and writes captured
//   pixels to a downstream FIFO.
//
//   Ports
//     rxClk          deserializer clock; all logic is on the rising edge
//     nrst           synchronous active-low reset
//     rx[27:0]       deserialized Camera Link bus
//     mode           geometry select (1: FULL, 0: HALF), latched at frame start
//     enable         capture enable, latched at frame start
//     fifo_full      downstream FIFO full
//     err_clr        one-cycle pulse that clears the sticky error flags
//     wr_en/pix_out  FIFO write strobe and recovered pixel (2-cycle latency)
//     frame_start    one-cycle pulse when a frame start is accepted
//     frame_done     one-cycle pulse at end of frame
//     frame_cnt      completed frame counter (wraps)
//     last_line_len  pixel count of the most recently closed line
//     line_len_err   sticky: a line length differed from the expected value
//     frame_len_err  sticky: a frame's line count differed from the expected value
//     overflow       sticky: a pixel was dropped because the FIFO was full
module cl_rx_deframer #(
    parameter int H_FULL = 1024,
    parameter int V_FULL = 1024,
    parameter int H_HALF = 1032,
    parameter int V_HALF = 512
) (
    input  logic        rxClk,
    input  logic        nrst,
    input  logic [27:0] rx,
    input  logic        mode,
    input  logic        enable,
    input  logic        fifo_full,
    input  logic        err_clr,
    output logic        wr_en,
    output logic [15:0] pix_out,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [10:0] last_line_len,
    output logic        line_len_err,
    output logic        frame_len_err,
    output logic        overflow
);

    typedef enum logic [1:0] {SYNC, IDLE, BLANK, LINE} state_t;

    localparam logic [10:0] CNT_MAX = 11'h7FF;

    // Input stage (no reset: it only mirrors the bus)
    logic [27:0] rx_q;

    always_ff @(posedge rxClk) begin
        rx_q <= rx;
    end

    // Base-config bit mapping
    logic        fval, lval, dval;
    logic [15:0] pix;
    logic        unused_rx_bits;

    always_comb begin
        fval       = rx_q[25];
        lval       = rx_q[24];
        dval       = rx_q[26];
        pix        = '0;
        pix[12:8]  = rx_q[4:0];
        pix[15]    = rx_q[5];
        pix[13]    = rx_q[6];
        pix[14]    = rx_q[27];
        pix[2:0]   = rx_q[9:7];
        pix[5:3]   = rx_q[14:12];
    end

    assign unused_rx_bits = ^{rx_q[23:15], rx_q[11:10]};

    // State and datapath registers
    state_t      state_q, state_d;
    logic [10:0] h_exp_q, h_exp_d;
    logic [10:0] v_exp_q, v_exp_d;
    logic        cap_en_q, cap_en_d;
    logic [10:0] pix_cnt_q, pix_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] pix_out_q, pix_out_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [10:0] last_len_q, last_len_d;
    logic        lle_q, lle_d;
    logic        fle_q, fle_d;
    logic        ovf_q, ovf_d;

    // Per-cycle events decoded by the output process
    logic ev_start, ev_pixel, ev_close, ev_eof;

    // FSM: state register
    always_ff @(posedge rxClk) begin
        if (!nrst) state_q <= SYNC;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (!fval) state_d = IDLE;
            IDLE:    if (fval)  state_d = lval ? LINE : BLANK;
            BLANK:   if (!fval) state_d = IDLE;
                     else if (lval) state_d = LINE;
            LINE:    if (!fval) state_d = IDLE;
                     else if (!lval) state_d = BLANK;
            default: state_d = SYNC;
        endcase
    end

    // FSM: event outputs. In LINE a drop of FVAL closes the line and the
    // frame together, whatever LVAL is doing.
    always_comb begin
        ev_start = 1'b0;
        ev_pixel = 1'b0;
        ev_close = 1'b0;
        ev_eof   = 1'b0;
        case (state_q)
            IDLE: begin
                ev_start = fval;
                ev_pixel = fval & lval;  // FVAL/LVAL rising together
            end
            BLANK: begin
                ev_eof   = ~fval;
                ev_pixel = fval & lval & dval;
            end
            LINE: begin
                if (!fval) begin
                    ev_close = 1'b1;
                    ev_eof   = 1'b1;
                end else if (!lval) begin
                    ev_close = 1'b1;
                end else begin
                    ev_pixel = dval;
                end
            end
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        h_exp_d       = h_exp_q;
        v_exp_d       = v_exp_q;
        cap_en_d      = cap_en_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        last_len_d    = last_len_q;
        frame_start_d = ev_start;
        frame_done_d  = ev_eof;
        pix_out_d     = pix;
        lle_d         = lle_q & ~err_clr;
        fle_d         = fle_q & ~err_clr;
        ovf_d         = ovf_q & ~err_clr;

        if (ev_start) begin
            h_exp_d    = mode ? 11'(H_FULL) : 11'(H_HALF);
            v_exp_d    = mode ? 11'(V_FULL) : 11'(V_HALF);
            cap_en_d   = enable;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
        end

        if (ev_pixel && pix_cnt_d != CNT_MAX) pix_cnt_d = pix_cnt_d + 11'd1;

        if (ev_close) begin
            last_len_d = pix_cnt_q;
            if (pix_cnt_q != h_exp_q) lle_d = 1'b1;
            if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 11'd1;
            pix_cnt_d = '0;
        end

        // line_cnt_d already includes a line closed in this same cycle
        if (ev_eof) begin
            if (line_cnt_d != v_exp_q) fle_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        // cap_en_d so the very first word of a frame uses the fresh enable
        wr_en_d = ev_pixel & cap_en_d & ~fifo_full;
        if (ev_pixel && cap_en_d && fifo_full) ovf_d = 1'b1;
    end

    always_ff @(posedge rxClk) begin
        if (!nrst) begin
            h_exp_q       <= '0;
            v_exp_q       <= '0;
            cap_en_q      <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            wr_en_q       <= 1'b0;
            pix_out_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            last_len_q    <= '0;
            lle_q         <= 1'b0;
            fle_q         <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            h_exp_q       <= h_exp_d;
            v_exp_q       <= v_exp_d;
            cap_en_q      <= cap_en_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            wr_en_q       <= wr_en_d;
            pix_out_q     <= pix_out_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            last_len_q    <= last_len_d;
            lle_q         <= lle_d;
            fle_q         <= fle_d;
            ovf_q         <= ovf_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign pix_out       = pix_out_q;
    assign frame_start   = frame_start_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;
    assign last_line_len = last_len_q;
    assign line_len_err  = lle_q;
    assign frame_len_err = fle_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_cl_rx_deframer.sv
// Directed bench for cl_rx_deframer with a small geometry (FULL 8x4,
// HALF 6x2). Expected pixels are queued when stimulus is driven; a monitor
// pops and compares on every wr_en. Flag/counter checks use hand-derived values.
module tb_cl_rx_deframer;

    logic        clk = 1'b0;
    logic        nrst;
    logic [27:0] rx;
    logic        mode, enable, fifo_full, err_clr;
    logic        wr_en;
    logic [15:0] pix_out;
    logic        frame_start, frame_done;
    logic [15:0] frame_cnt;
    logic [10:0] last_line_len;
    logic        line_len_err, frame_len_err, overflow;

    cl_rx_deframer #(.H_FULL(8), .V_FULL(4), .H_HALF(6), .V_HALF(2)) dut (
        .rxClk(clk), .nrst(nrst), .rx(rx), .mode(mode), .enable(enable),
        .fifo_full(fifo_full), .err_clr(err_clr), .wr_en(wr_en),
        .pix_out(pix_out), .frame_start(frame_start), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .last_line_len(last_line_len),
        .line_len_err(line_len_err), .frame_len_err(frame_len_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] sbq[$];
    int          wr_cnt = 0, st_cnt = 0, dn_cnt = 0;
    logic        dn_fle = 1'b0;
    bit          full_pend = 1'b0;

    // Monitor: samples registered outputs on the falling edge
    always @(negedge clk) begin
        logic [15:0] e;
        if (wr_en) begin
            wr_cnt++;
            n_chk++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: pix_out=%h, required no write", pix_out);
            end else begin
                e = sbq.pop_front();
                if (pix_out !== e) begin
                    n_err++;
                    $display("FAIL pix_out: got %h required %h", pix_out, e);
                end
            end
        end
        if (frame_start) st_cnt++;
        if (frame_done) begin
            dn_cnt++;
            dn_fle = frame_len_err;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Pixel bits [7:6] go into the ignored rx[11:10] to show they are dropped
    function automatic logic [27:0] enc(bit f, bit l, bit d, logic [15:0] p);
        logic [27:0] r;
        r        = '0;
        r[4:0]   = p[12:8];
        r[5]     = p[15];
        r[6]     = p[13];
        r[27]    = p[14];
        r[9:7]   = p[2:0];
        r[14:12] = p[5:3];
        r[11:10] = p[7:6];
        r[23:15] = 9'h1A5;
        r[25]    = f;
        r[24]    = l;
        r[26]    = d;
        return r;
    endfunction

    // fifo_full is delayed one cycle so it lines up with the word's decode cycle
    task automatic drv(bit f, bit l, bit d, logic [15:0] p, bit full, bit exp_wr);
        @(negedge clk);
        rx        = enc(f, l, d, p);
        fifo_full = full_pend;
        full_pend = full;
        if (exp_wr) sbq.push_back(p & 16'hFF3F);
    endtask

    task automatic idle(int n);
        repeat (n) drv(0, 0, 0, 16'h0, 0, 0);
    endtask

    task automatic line(int n, logic [15:0] base, int flo, int fhi, bit cap);
        for (int i = 0; i < n; i++) begin
            bit full;
            full = (i >= flo) && (i <= fhi);
            drv(1, 1, 1, base + 16'(i), full, cap && !full);
        end
        repeat (3) drv(1, 0, 0, 16'h0, 0, 0);
    endtask

    task automatic frame(int nl, int len, int short_ln, int short_len, int flo, int fhi, bit cap);
        for (int ln = 0; ln < nl; ln++)
            line((ln == short_ln) ? short_len : len,
                 16'h01C0 ^ 16'(ln * 16'h5240),
                 (ln == 0) ? flo : 99, (ln == 0) ? fhi : -1, cap);
        idle(4);
        #2;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(1);
        #2;
    endtask

    function automatic logic [63:0] outs();
        return {15'h0, wr_en, pix_out, frame_start, frame_done, frame_cnt,
                last_line_len, line_len_err, frame_len_err, overflow};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, s0, d0;
        nrst = 1'b0; rx = '0; mode = 1'b1; enable = 1'b1;
        fifo_full = 1'b0; err_clr = 1'b0;
        idle(3);
        #2;
        chk("reset_outs", outs(), 64'h0);
        nrst = 1'b1;
        idle(4);

        // T1: 4 lines x 8 px, clean frame
        frame(4, 8, -1, 0, 99, -1, 1);
        chk("t1_writes", 64'(wr_cnt), 64'd32);
        chk("t1_starts", 64'(st_cnt), 64'd1);
        chk("t1_dones", 64'(dn_cnt), 64'd1);
        chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t1_flags", {61'h0, line_len_err, frame_len_err, overflow}, 64'h0);
        chk("t1_last_len", 64'(last_line_len), 64'd8);
        chk("t1_fle_at_done", 64'(dn_fle), 64'd0);

        // T2: third line short
        line(8, 16'h0100, 99, -1, 1);
        line(8, 16'hC1C0, 99, -1, 1);
        line(7, 16'h2A00, 99, -1, 1);
        #2;
        chk("t2_last_len_short", 64'(last_line_len), 64'd7);
        chk("t2_lle_set", 64'(line_len_err), 64'd1);
        line(8, 16'h5100, 99, -1, 1);
        idle(4);
        #2;
        chk("t2_last_len", 64'(last_line_len), 64'd8);
        chk("t2_fle", 64'(frame_len_err), 64'd0);
        chk("t2_lle_held", 64'(line_len_err), 64'd1);
        clr();
        chk("t2_lle_clr", 64'(line_len_err), 64'd0);

        // T3: 3 lines against V=4
        frame(3, 8, -1, 0, 99, -1, 1);
        chk("t3_fle_at_done", 64'(dn_fle), 64'd1);
        chk("t3_fle", 64'(frame_len_err), 64'd1);
        chk("t3_lle", 64'(line_len_err), 64'd0);
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd3);
        clr();

        // T4: fifo_full on pixels 2..4 of line 1
        w0 = wr_cnt;
        frame(4, 8, -1, 0, 1, 3, 1);
        chk("t4_writes", 64'(wr_cnt - w0), 64'd29);
        chk("t4_ovf", 64'(overflow), 64'd1);
        chk("t4_lle", 64'(line_len_err), 64'd0);
        chk("t4_fle", 64'(frame_len_err), 64'd0);
        clr();
        chk("t4_ovf_clr", 64'(overflow), 64'd0);

        // T5: reset mid-line, released while FVAL high
        w0 = wr_cnt; s0 = st_cnt;
        drv(1, 1, 1, 16'h0A01, 0, 1);
        drv(1, 1, 1, 16'h0A02, 0, 0);
        drv(1, 1, 1, 16'h0A03, 0, 0);
        nrst = 1'b0;
        drv(1, 1, 1, 16'h0A04, 0, 0);
        drv(1, 1, 1, 16'h0A05, 0, 0);
        #2;
        chk("t5_outs_in_reset", outs(), 64'h0);
        nrst = 1'b1;
        for (int i = 5; i < 8; i++) drv(1, 1, 1, 16'h0A00 + 16'(i), 0, 0);
        repeat (3) drv(1, 0, 0, 16'h0, 0, 0);
        line(8, 16'h0B00, 99, -1, 0);
        #2;
        chk("t5_no_writes", 64'(wr_cnt - w0), 64'd1);
        chk("t5_no_start", 64'(st_cnt - s0), 64'd1);
        idle(4);
        frame(4, 8, -1, 0, 99, -1, 1);
        chk("t5_writes_after", 64'(wr_cnt - w0), 64'd33);
        chk("t5_start_after", 64'(st_cnt - s0), 64'd2);
        chk("t5_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t5_flags", {61'h0, line_len_err, frame_len_err, overflow}, 64'h0);

        // T6: mode 1->0 mid-frame
        line(8, 16'h3300, 99, -1, 1);
        mode = 1'b0;
        line(8, 16'h3400, 99, -1, 1);
        line(8, 16'h3500, 99, -1, 1);
        line(8, 16'h3600, 99, -1, 1);
        idle(4);
        #2;
        chk("t6_full_flags", {61'h0, line_len_err, frame_len_err, overflow}, 64'h0);
        frame(2, 6, -1, 0, 99, -1, 1);
        chk("t6_half_flags", {61'h0, line_len_err, frame_len_err, overflow}, 64'h0);
        chk("t6_half_len", 64'(last_line_len), 64'd6);

        // T7: capture disabled, counting still runs
        mode = 1'b1; enable = 1'b0;
        idle(2);
        w0 = wr_cnt; d0 = dn_cnt;
        frame(4, 7, -1, 0, 99, -1, 0);
        chk("t7_no_writes", 64'(wr_cnt - w0), 64'd0);
        chk("t7_done", 64'(dn_cnt - d0), 64'd1);
        chk("t7_lle", 64'(line_len_err), 64'd1);

        idle(4);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
